// File: rtl/muldiv_unit.sv
// Multi-cycle MIPS multiply/divide unit holding the architectural HI/LO registers.
// Radix-2 shift-add multiply and restoring divide, one bit per clock.
`timescale 1ns/1ps
module muldiv_unit #(
    parameter int NB_DATA    = 32,
    parameter int NB_CONTROL = 6
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [NB_CONTROL-1:0] i_op,
    input  logic [NB_DATA-1:0]    i_operand_a,
    input  logic [NB_DATA-1:0]    i_operand_b,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_div_by_zero,
    output logic [NB_DATA-1:0]    o_hi,
    output logic [NB_DATA-1:0]    o_lo
);

    localparam int ACC_W = 2 * NB_DATA + 1;
    localparam int CNT_W = $clog2(NB_DATA + 1);

    localparam logic [NB_CONTROL-1:0] OP_MULT  = NB_CONTROL'(6'b011000);
    localparam logic [NB_CONTROL-1:0] OP_MULTU = NB_CONTROL'(6'b011001);
    localparam logic [NB_CONTROL-1:0] OP_DIV   = NB_CONTROL'(6'b011010);
    localparam logic [NB_CONTROL-1:0] OP_DIVU  = NB_CONTROL'(6'b011011);
    localparam logic [NB_CONTROL-1:0] OP_MTHI  = NB_CONTROL'(6'b010001);
    localparam logic [NB_CONTROL-1:0] OP_MTLO  = NB_CONTROL'(6'b010011);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t               state_r;
    logic                 busy_r, done_r, dbz_r;
    logic                 is_div_r, zero_r, neg_res_r, neg_rem_r;
    logic [NB_DATA-1:0]   hi_r, lo_r, opnd_r;
    logic [ACC_W-1:0]     acc_r;
    logic [CNT_W-1:0]     cnt_r;

    logic                 op_valid_s, op_signed_s, op_is_div_s;
    logic [NB_DATA-1:0]   abs_a_s, abs_b_s;
    logic [NB_DATA:0]     mul_sum_s, rem_shift_s;
    logic [NB_DATA+1:0]   div_diff_s;
    logic [ACC_W-1:0]     mul_next_s, div_next_s, step_s;
    logic [2*NB_DATA-1:0] prod_s;
    logic [NB_DATA-1:0]   quot_s, rem_s;

    function automatic logic is_valid_op(input logic [NB_CONTROL-1:0] op);
        case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO: return 1'b1;
            default:                                              return 1'b0;
        endcase
    endfunction

    function automatic logic [NB_DATA-1:0] magnitude(input logic [NB_DATA-1:0] v,
                                                     input logic             take_abs);
        return (take_abs && v[NB_DATA-1]) ? (~v + NB_DATA'(1)) : v;
    endfunction

    // Operand decode and sign stripping at acceptance.
    always_comb begin
        op_valid_s  = is_valid_op(i_op);
        op_signed_s = (i_op == OP_MULT) || (i_op == OP_DIV);
        op_is_div_s = (i_op == OP_DIV) || (i_op == OP_DIVU);
        abs_a_s     = magnitude(i_operand_a, op_signed_s);
        abs_b_s     = magnitude(i_operand_b, op_signed_s);
    end

    // One iteration step: acc = {partial sum/remainder (N+1), multiplier/quotient (N)}.
    always_comb begin
        mul_sum_s   = acc_r[ACC_W-1:NB_DATA] + (acc_r[0] ? {1'b0, opnd_r} : {(NB_DATA+1){1'b0}});
        mul_next_s  = {1'b0, mul_sum_s, acc_r[NB_DATA-1:1]};
        rem_shift_s = acc_r[2*NB_DATA-1:NB_DATA-1];
        div_diff_s  = {1'b0, rem_shift_s} - {2'b00, opnd_r};
        div_next_s  = div_diff_s[NB_DATA+1] ? {rem_shift_s, acc_r[NB_DATA-2:0], 1'b0}
                                            : {div_diff_s[NB_DATA:0], acc_r[NB_DATA-2:0], 1'b1};
        step_s      = is_div_r ? div_next_s : mul_next_s;
    end

    // Sign correction of the final step's result (|MIN|/1 naturally wraps back to MIN).
    always_comb begin
        prod_s = neg_res_r ? (~mul_next_s[2*NB_DATA-1:0] + (2*NB_DATA)'(1))
                           : mul_next_s[2*NB_DATA-1:0];
        quot_s = neg_res_r ? (~div_next_s[NB_DATA-1:0] + NB_DATA'(1))
                           : div_next_s[NB_DATA-1:0];
        rem_s  = neg_rem_r ? (~div_next_s[2*NB_DATA-1:NB_DATA] + NB_DATA'(1))
                           : div_next_s[2*NB_DATA-1:NB_DATA];
    end

    // Control FSM, iteration datapath and HI/LO architectural state.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r   <= IDLE;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            dbz_r     <= 1'b0;
            is_div_r  <= 1'b0;
            zero_r    <= 1'b0;
            neg_res_r <= 1'b0;
            neg_rem_r <= 1'b0;
            hi_r      <= '0;
            lo_r      <= '0;
            opnd_r    <= '0;
            acc_r     <= '0;
            cnt_r     <= '0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (i_start && op_valid_s) begin
                        dbz_r <= 1'b0;
                        case (i_op)
                            OP_MTHI: hi_r <= i_operand_a;
                            OP_MTLO: lo_r <= i_operand_a;
                            default: begin
                                state_r   <= RUN;
                                busy_r    <= 1'b1;
                                is_div_r  <= op_is_div_s;
                                zero_r    <= op_is_div_s && (i_operand_b == '0);
                                neg_res_r <= op_signed_s && (i_operand_a[NB_DATA-1] ^ i_operand_b[NB_DATA-1]);
                                neg_rem_r <= op_signed_s && i_operand_a[NB_DATA-1];
                                opnd_r    <= abs_b_s;
                                acc_r     <= {{(NB_DATA+1){1'b0}}, abs_a_s};
                                cnt_r     <= CNT_W'(NB_DATA);
                            end
                        endcase
                    end
                end
                RUN: begin
                    if (zero_r) begin
                        zero_r  <= 1'b0;
                        dbz_r   <= 1'b1;
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        acc_r <= step_s;
                        cnt_r <= cnt_r - CNT_W'(1);
                        if (cnt_r == CNT_W'(1)) begin
                            if (is_div_r) begin
                                hi_r <= rem_s;
                                lo_r <= quot_s;
                            end else begin
                                {hi_r, lo_r} <= prod_s;
                            end
                            done_r  <= 1'b1;
                            busy_r  <= 1'b0;
                            state_r <= IDLE;
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy        = busy_r;
    assign o_done        = done_r;
    assign o_div_by_zero = dbz_r;
    assign o_hi          = hi_r;
    assign o_lo          = lo_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed table, hand sequences for
// mid-run/reset corners, an 8-bit build, and random ops against an arithmetic model.
`timescale 1ns/1ps
module tb_muldiv_unit;

    localparam logic [5:0] OP_MULT  = 6'b011000;
    localparam logic [5:0] OP_MULTU = 6'b011001;
    localparam logic [5:0] OP_DIV   = 6'b011010;
    localparam logic [5:0] OP_DIVU  = 6'b011011;
    localparam logic [5:0] OP_MTHI  = 6'b010001;
    localparam logic [5:0] OP_MTLO  = 6'b010011;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [5:0]  op;
    logic [31:0] a, b, hi, lo;
    logic        busy, done, dbz;

    logic        start8;
    logic [5:0]  op8;
    logic [7:0]  a8, b8, hi8, lo8;
    logic        busy8, done8, dbz8;

    int errors = 0;
    int checks = 0;

    logic [31:0] m_hi, m_lo;
    logic        m_dbz;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] a, b, hi, lo;
        logic        dbz;
        int          lat;
    } vec_t;
    vec_t tbl[12];

    always #5 clk = ~clk;

    muldiv_unit #(.NB_DATA(32), .NB_CONTROL(6)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_op(op),
        .i_operand_a(a), .i_operand_b(b), .o_busy(busy), .o_done(done),
        .o_div_by_zero(dbz), .o_hi(hi), .o_lo(lo)
    );

    muldiv_unit #(.NB_DATA(8), .NB_CONTROL(6)) dut8 (
        .i_clk(clk), .i_rst(rst), .i_start(start8), .i_op(op8),
        .i_operand_a(a8), .i_operand_b(b8), .o_busy(busy8), .o_done(done8),
        .o_div_by_zero(dbz8), .o_hi(hi8), .o_lo(lo8)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Architectural reference: plain integer arithmetic on 64-bit values.
    task automatic model(input logic [5:0] o, input logic [31:0] x, input logic [31:0] y,
                         output int lat);
        longint sx, sy;
        sx    = longint'($signed(x));
        sy    = longint'($signed(y));
        m_dbz = 1'b0;
        lat   = 32;
        case (o)
            OP_MULT:  {m_hi, m_lo} = 64'(sx * sy);
            OP_MULTU: {m_hi, m_lo} = {32'd0, x} * {32'd0, y};
            OP_DIV: begin
                if (y == 32'd0) begin m_dbz = 1'b1; lat = 1; end
                else begin m_lo = 32'(sx / sy); m_hi = 32'(sx % sy); end
            end
            OP_DIVU: begin
                if (y == 32'd0) begin m_dbz = 1'b1; lat = 1; end
                else begin m_lo = x / y; m_hi = x % y; end
            end
            OP_MTHI: begin m_hi = x; lat = 0; end
            OP_MTLO: begin m_lo = x; lat = 0; end
            default: lat = 0;
        endcase
    endtask

    task automatic issue(input logic [5:0] o, input logic [31:0] x, input logic [31:0] y,
                         input int exp_lat, input string tag);
        int lat;
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, " busy_after_accept"}, busy, exp_lat != 0);
        check({tag, " done_low_after_accept"}, done, 1'b0);
        lat = 0;
        if (exp_lat != 0) begin
            while (done !== 1'b1 && lat < 100) begin
                @(posedge clk); #1;
                lat++;
            end
            check({tag, " latency"}, lat, exp_lat);
            check({tag, " busy_at_done"}, busy, 1'b0);
        end
        check({tag, " hi"}, hi, m_hi);
        check({tag, " lo"}, lo, m_lo);
        check({tag, " div_by_zero"}, dbz, m_dbz);
    endtask

    initial begin
        int lat;
        logic [5:0] rops[6];
        logic [31:0] x, y;
        rops = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO};

        tbl[0]  = '{OP_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 32};
        tbl[1]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 32};
        tbl[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 32};
        tbl[3]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 32};
        tbl[4]  = '{OP_DIVU,  32'h12345678, 32'h00000000, 32'h00000000, 32'h80000000, 1'b1, 1};
        tbl[5]  = '{OP_MTLO,  32'h00001234, 32'h00000000, 32'h00000000, 32'h00001234, 1'b0, 0};
        tbl[6]  = '{OP_MTHI,  32'hCAFEF00D, 32'h00000009, 32'hCAFEF00D, 32'h00001234, 1'b0, 0};
        tbl[7]  = '{OP_DIVU,  32'h00000100, 32'h00000007, 32'h00000004, 32'h00000024, 1'b0, 32};
        tbl[8]  = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 32};
        tbl[9]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 32};
        tbl[10] = '{OP_DIV,   32'h00000000, 32'h00000005, 32'h00000000, 32'h00000000, 1'b0, 32};
        tbl[11] = '{OP_DIV,   32'h00000005, 32'h00000000, 32'h00000000, 32'h00000000, 1'b1, 1};

        rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        start8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset hi", hi, 32'd0);
        check("reset lo", lo, 32'd0);
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        check("reset dbz", dbz, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        m_hi = '0; m_lo = '0; m_dbz = 1'b0;

        for (int i = 0; i < 12; i++) begin
            m_hi = tbl[i].hi; m_lo = tbl[i].lo; m_dbz = tbl[i].dbz;
            issue(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].lat, $sformatf("vec%0d", i));
        end

        // Unrecognised op codes must leave everything untouched.
        model(OP_MTHI, 32'h0BAD0BAD, 32'd0, lat);
        issue(OP_MTHI, 32'h0BAD0BAD, 32'd0, lat, "mthi_pre_invalid");
        @(negedge clk); start = 1'b1; op = 6'b000000; a = 32'hFFFF0000;
        @(negedge clk); op = 6'b011100;
        @(negedge clk); start = 1'b0;
        @(posedge clk); #1;
        check("invalid busy", busy, 1'b0);
        check("invalid done", done, 1'b0);
        check("invalid hi", hi, m_hi);
        check("invalid lo", lo, m_lo);

        // A second start while busy is dropped.
        @(negedge clk); start = 1'b1; op = OP_MULT; a = 32'd6; b = 32'd7;
        @(posedge clk); #1; start = 1'b0; lat = 0;
        while (done !== 1'b1 && lat < 100) begin
            if (lat == 5) begin start = 1'b1; op = OP_MULTU; a = 32'd3; b = 32'd3; end
            else start = 1'b0;
            if (lat == 10) check("midrun lo holds", lo, m_lo);
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        m_hi = 32'd0; m_lo = 32'd42;
        check("midrun latency", lat, 32);
        check("midrun hi", hi, m_hi);
        check("midrun lo", lo, m_lo);

        // Asynchronous reset in the middle of an iteration.
        model(OP_DIVU, 32'd77, 32'd0, lat);
        issue(OP_DIVU, 32'd77, 32'd0, lat, "dbz_pre_reset");
        @(negedge clk); start = 1'b1; op = OP_MULTU; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF;
        @(posedge clk); #1; start = 1'b0;
        repeat (10) @(posedge clk);
        #2; rst = 1'b1; #1;
        check("async rst hi", hi, 32'd0);
        check("async rst lo", lo, 32'd0);
        check("async rst busy", busy, 1'b0);
        check("async rst done", done, 1'b0);
        check("async rst dbz", dbz, 1'b0);
        @(negedge clk); rst = 1'b0;
        m_hi = '0; m_lo = '0; m_dbz = 1'b0;
        model(OP_MULT, 32'd6, 32'd7, lat);
        issue(OP_MULT, 32'd6, 32'd7, lat, "post_reset_mult");

        // 8-bit build: signed 0x80 * 0x80.
        @(negedge clk); start8 = 1'b1; op8 = OP_MULT; a8 = 8'h80; b8 = 8'h80;
        @(posedge clk); #1; start8 = 1'b0; lat = 0;
        while (done8 !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check("nb8 latency", lat, 8);
        check("nb8 hi", hi8, 8'h40);
        check("nb8 lo", lo8, 8'h00);

        for (int i = 0; i < 40; i++) begin
            string tag;
            logic [5:0] o;
            o = rops[$urandom_range(0, 5)];
            x = $urandom;
            y = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) y = y & 32'h0000000F;
            tag = $sformatf("rand%0d", i);
            model(o, x, y, lat);
            issue(o, x, y, lat, tag);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Multi-cycle multiply/divide unit for the EX stage, generalising the single-cycle ALU to the MIPS MULT/MULTU/DIV/DIVU and MTHI/MTLO operations. It holds the architectural HI/LO registers and exposes them to the forwarding and MFHI/MFLO path. Width is parametrised; iteration latency scales with NB_DATA. A start/busy/done handshake lets the hazard unit stall the pipeline while an operation is in flight.

Parameters:
NB_DATA, 32, operand, HI and LO width; also the iteration count.
NB_CONTROL, 6, width of the op code (MIPS funct field).

Ports:
i_clk  input  1  clock; all state updates on the rising edge.
i_rst  input  1  reset, asynchronous, active-high.
i_start  input  1  request; sampled only when o_busy=0.
i_op  input  NB_CONTROL  011000 MULT, 011001 MULTU, 011010 DIV, 011011 DIVU, 010001 MTHI, 010011 MTLO.
i_operand_a  input  NB_DATA  rs: multiplicand, dividend, or MT source.
i_operand_b  input  NB_DATA  rt: multiplier or divisor.
o_busy  output  1  an operation is in flight.
o_done  output  1  one-cycle pulse: HI/LO were updated by MULT/DIV at this edge.
o_div_by_zero  output  1  last accepted DIV/DIVU had divisor 0; sticky until the next accepted op.
o_hi  output  NB_DATA  HI register.
o_lo  output  NB_DATA  LO register.

Behaviour:
- Reset (async, any state, including mid-operation):
  - state=IDLE.
  - o_hi, o_lo, o_busy, o_done and o_div_by_zero all 0.
  - Iteration counter and working registers cleared.
  - An in-flight operation is discarded.
- FSM states:
  - IDLE: o_busy=0.
  - RUN: o_busy=1.
- Acceptance at edge E0 (state=IDLE, i_start=1, i_op valid):
  - MTHI/MTLO: HI (or LO) is written from i_operand_a at E0.
  - MTHI/MTLO: state stays IDLE, o_done stays 0, o_div_by_zero cleared.
  - MULT/DIV family: operands are latched. For signed ops, magnitudes are latched along with the result sign flags.
  - MULT/DIV family: counter=NB_DATA, state goes to RUN, o_div_by_zero cleared.
- Invalid op codes:
  - An unrecognised i_op with i_start=1 is ignored (no state change).
  - i_start while o_busy=1 is ignored; there is no queuing.
- MULT/MULTU:
  - Radix-2 shift-add, one bit per edge, E1..E_NB_DATA.
  - At E_NB_DATA: {HI,LO} = 2*NB_DATA-bit product, sign-corrected for MULT.
  - At the same edge: o_done=1 for one cycle, state goes to IDLE, o_busy=0.
- DIV/DIVU:
  - Restoring division, one quotient bit per edge.
  - Results are written at E_NB_DATA, with the same done/busy timing as multiply.
  - LO = quotient, truncated toward zero.
  - HI = remainder, carrying the sign of the dividend (DIV).
  - Signed overflow (MIN / -1): LO = MIN, HI = 0; no flag.
- Divide by zero (DIV/DIVU with i_operand_b==0 at acceptance):
  - No iteration is performed.
  - At E1: o_done=1, o_div_by_zero=1, HI/LO unchanged, state goes to IDLE.
- Latency from acceptance to o_done:
  - NB_DATA cycles for MULT/DIV.
  - 1 cycle for divide by zero.
- Output timing:
  - o_hi/o_lo are registered and change only at write edges.
  - Between writes they hold stable; during RUN they show the previous values.
- Accepting a new op in the cycle after o_done is legal (back-to-back).
- Widths: internal accumulator is 2*NB_DATA+1 bits; no truncation before the final write.

Test Plan:
- Reset, then MULT a=0xFFFFFFFD (-3), b=5 -> o_busy high 32 cycles; o_done at E32; HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- MULTU a=b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001, o_done one cycle.
- DIV a=-7, b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV a=0x80000000, b=-1 -> LO=0x80000000, HI=0.
- DIVU b=0 -> o_done and o_div_by_zero at E1; HI/LO keep prior values; the next MTLO 0x1234 clears the flag and LO=0x1234 with no o_done.
- i_start=1 with a second op mid-RUN -> ignored, first result correct.
- i_rst asserted at iteration 10 -> all outputs 0 immediately (asynchronous); a subsequent MULT 6*7 gives LO=42, HI=0.
- NB_DATA=8 build -> MULT 0x80*0x80 gives HI=0x40, LO=0x00 at E8.
